// File: rtl/sram_axi_bridge_if.sv
// AXI read/write channel bundle between the SRAM-to-AXI bridge and the interconnect.
// Only the single-beat subset the bridge drives is carried; IDs/burst/size/cache/prot are tied off upstream.
interface sram_axi_bridge_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Turns the core's inst/data SRAM-like requests into single-beat AXI transfers,
// stalling the core until every enabled port has been served once.
module sram_axi_bridge #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  sram_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_DONE
  } state_t;

  state_t      state_q, state_n;
  logic        inst_done_q, data_done_q;
  logic        cur_data_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic inst_pend, data_pend, pick_data;
  logic ld_rd, ld_wr, cap_inst, cap_data, set_data_done, clr_done;
  logic aw_ok, w_ok;

  assign inst_pend = inst_sram_en & ~inst_done_q;
  assign data_pend = data_sram_en & ~data_done_q;
  // Arbitration only matters when both ports are waiting in the same cycle.
  assign pick_data = data_pend & (DATA_FIRST | ~inst_pend);

  // A write channel is finished once its valid has dropped or is being accepted now.
  assign aw_ok = ~awvalid_q | axi.awready;
  assign w_ok  = ~wvalid_q  | axi.wready;

  always_comb begin
    state_n       = state_q;
    ld_rd         = 1'b0;
    ld_wr         = 1'b0;
    cap_inst      = 1'b0;
    cap_data      = 1'b0;
    set_data_done = 1'b0;
    clr_done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inst_pend | data_pend) begin
          if (pick_data && (|data_sram_wen)) begin
            ld_wr   = 1'b1;
            state_n = S_AW_W;
          end else begin
            ld_rd   = 1'b1;
            state_n = S_AR;
          end
        end
      end
      S_AR: begin
        if (axi.arready) state_n = S_R;
      end
      S_R: begin
        if (axi.rvalid) begin
          if (cur_data_q) begin
            cap_data = 1'b1;
            state_n  = inst_pend ? S_IDLE : S_DONE;
          end else begin
            cap_inst = 1'b1;
            state_n  = data_pend ? S_IDLE : S_DONE;
          end
        end
      end
      S_AW_W: begin
        if (aw_ok && w_ok) state_n = S_B;
      end
      S_B: begin
        if (axi.bvalid) begin
          set_data_done = 1'b1;
          state_n       = inst_pend ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        clr_done = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else if (clr_done) begin
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      if (cap_inst)                 inst_done_q <= 1'b1;
      if (cap_data | set_data_done) data_done_q <= 1'b1;
    end
  end

  // Request latch: address and store payload are frozen for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_data_q <= 1'b0;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      if (ld_rd) begin
        cur_data_q <= pick_data;
        araddr_q   <= pick_data ? data_sram_addr : inst_sram_addr;
      end
      if (ld_wr) begin
        cur_data_q <= 1'b1;
        awaddr_q   <= data_sram_addr;
        wdata_q    <= data_sram_wdata;
        wstrb_q    <= data_sram_wen;
        awvalid_q  <= 1'b1;
        wvalid_q   <= 1'b1;
      end else if (state_q == S_AW_W) begin
        if (axi.awready) awvalid_q <= 1'b0;
        if (axi.wready)  wvalid_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (cap_inst) inst_rdata_q <= axi.rdata;
      if (cap_data) data_rdata_q <= axi.rdata;
    end
  end

  assign stallreq        = (state_q != S_DONE) & (inst_pend | data_pend);
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  assign axi.araddr  = araddr_q;
  assign axi.arvalid = (state_q == S_AR);
  assign axi.rready  = (state_q == S_R);
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (state_q == S_B);

endmodule
